// File: rtl/bus_mem_resp_if.sv
// CPU-side and program-load signals of the ROM/RAM responder.
// The shared data bus stays a plain inout port on the module.
interface bus_mem_resp_if #(
    parameter int DW = 8,
    parameter int AW = 6,
    parameter int IW = 5
);
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic          prog_en;
    logic [IW-1:0] prog_addr;
    logic [DW-1:0] prog_data;
    logic          rom_sel;
    logic          ram_sel;
    logic          bus_err;

    modport master (
        output rd, wr, addr, prog_en, prog_addr, prog_data,
        input  rom_sel, ram_sel, bus_err
    );

    modport slave (
        input  rd, wr, addr, prog_en, prog_addr, prog_data,
        output rom_sel, ram_sel, bus_err
    );
endinterface

// File: rtl/bus_mem_resp.sv
// ROM/RAM bus responder: loadable ROM in the low half, RAM in the high half.
// Handshake: rd/wr are level strobes; a read drives data one edge after entry, a write commits once per pulse.
module bus_mem_resp #(
    parameter int DW    = 8,
    parameter int AW    = 6,
    parameter int DEPTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    bus_mem_resp_if.slave   bus,
    inout  wire  [DW-1:0]   data,
    output logic [1:0]      fsm_state,
    output logic            data_en
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        PROG = 2'd3
    } state_t;

    state_t        state;
    logic [DW-1:0] rom [DEPTH];
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] rdata;
    logic [DW-1:0] word;
    logic [IW-1:0] idx;
    logic          bus_err;

    assign idx         = bus.addr[IW-1:0];
    assign bus.rom_sel = (bus.rd | bus.wr) & ~bus.addr[AW-1];
    assign bus.ram_sel = (bus.rd | bus.wr) &  bus.addr[AW-1];
    assign bus.bus_err = bus_err;
    assign fsm_state   = state;

    // Bus is released the moment rd drops, without waiting for the FSM.
    assign data_en = (state == RD) && bus.rd;
    assign data    = data_en ? rdata : {DW{1'bz}};

    always_comb begin
        word = bus.addr[AW-1] ? ram[idx] : rom[idx];
    end

    // ROM has no reset so its image survives a CPU reset.
    always_ff @(posedge clk) begin
        if (reset && bus.prog_en && (state == IDLE || state == PROG)) begin
            rom[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            bus_err <= 1'b0;
            rdata   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ram[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.prog_en) begin
                        state <= PROG;
                    end else if (bus.rd && bus.wr) begin
                        bus_err <= 1'b1;
                    end else if (bus.rd) begin
                        state <= RD;
                        rdata <= word;
                    end else if (bus.wr) begin
                        state <= WR;
                        if (bus.addr[AW-1]) begin
                            ram[idx] <= data;
                        end else begin
                            bus_err <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (!bus.rd) begin
                        state <= IDLE;
                    end else begin
                        rdata <= word;
                        if (bus.wr) begin
                            bus_err <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (bus.rd) begin
                        bus_err <= 1'b1;
                    end
                    if (!bus.wr) begin
                        state <= IDLE;
                    end
                end
                PROG: begin
                    if (!bus.prog_en) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_mem_resp.sv
// Self-checking bench for bus_mem_resp: reference ROM/RAM model plus a read-data queue.
module tb_bus_mem_resp;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tb_dout;
    logic       tb_oe;
    wire  [7:0] data;
    logic [1:0] fsm_state;
    logic       data_en;

    logic [7:0] rom_m [32];
    logic [7:0] ram_m [32];
    logic       err_m;
    logic [7:0] exp_q [$];
    int         total = 0;
    int         bad   = 0;

    bus_mem_resp_if #(.DW(8), .AW(6), .IW(5)) bus ();

    bus_mem_resp #(.DW(8), .AW(6), .DEPTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .data      (data),
        .fsm_state (fsm_state),
        .data_en   (data_en)
    );

    assign data = tb_oe ? tb_dout : 8'bz;

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_word(input logic [5:0] a);
        return a[5] ? ram_m[a[4:0]] : rom_m[a[4:0]];
    endfunction

    task automatic check_state(input string name, input logic [1:0] st, input logic er, input logic en);
        total++;
        if (fsm_state !== st || bus.bus_err !== er || data_en !== en) begin
            bad++;
            $display("FAIL %s: state=%0d bus_err=%b data_en=%b, required state=%0d bus_err=%b data_en=%b",
                     name, fsm_state, bus.bus_err, data_en, st, er, en);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        for (int i = 0; i < 32; i++) ram_m[i] = 8'h00;
        err_m = 1'b0;
        reset = 1'b1;
    endtask

    // rd held while addr walks; each sampled word was queued when its addr was driven.
    task automatic read_burst(input string name, input logic [5:0] a0, input int n);
        logic [7:0] got;
        logic [7:0] want;
        logic [5:0] a;
        bus.rd = 1'b1;
        for (int k = 0; k < n; k++) begin
            a = a0 + 6'(k);
            bus.addr = a;
            exp_q.push_back(exp_word(a));
            #1;
            total++;
            if (bus.rom_sel !== ~a[5] || bus.ram_sel !== a[5]) begin
                bad++;
                $display("FAIL %s_sel: addr=%h rom_sel=%b ram_sel=%b, required %b %b",
                         name, a, bus.rom_sel, bus.ram_sel, ~a[5], a[5]);
            end
            step();
            got  = data;
            want = exp_q.pop_front();
            total++;
            if (data_en !== 1'b1 || got !== want) begin
                bad++;
                $display("FAIL %s_data: addr=%h data_en=%b data=%h, required data_en=1 data=%h",
                         name, a, data_en, got, want);
            end
        end
        bus.rd = 1'b0;
        #1;
        total++;
        if (data_en !== 1'b0) begin
            bad++;
            $display("FAIL %s_release: data_en=%b after rd fell, required 0", name, data_en);
        end
        step();
        check_state({name, "_idle"}, 2'd0, err_m, 1'b0);
    endtask

    task automatic write_pulse(input logic [5:0] a, input logic [7:0] v, input int cycles, input logic [7:0] alt);
        bus.wr   = 1'b1;
        bus.addr = a;
        tb_oe    = 1'b1;
        tb_dout  = v;
        step();
        if (a[5]) ram_m[a[4:0]] = v;
        else      err_m = 1'b1;
        tb_dout = alt;
        for (int k = 1; k < cycles; k++) step();
        bus.wr = 1'b0;
        tb_oe  = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0;
        bus.prog_en = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
        tb_oe = 1'b0; tb_dout = '0;
        step(); step(); step();
        check_state("reset", 2'd0, 1'b0, 1'b0);
        do_reset();
    endtask

    task automatic test_prog();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        bus.prog_en = 1'b1;
        bus.rd      = 1'b1;
        bus.addr    = 6'h21;
        bus.prog_addr = 5'd0; bus.prog_data = vals[0];
        step();
        for (int i = 0; i < 4; i++) begin
            bus.prog_addr = 5'(i);
            bus.prog_data = vals[i];
            rom_m[i] = vals[i];
            step();
        end
        check_state("prog_state", 2'd3, 1'b0, 1'b0);
        bus.prog_en = 1'b0;
        bus.rd      = 1'b0;
        step();
        check_state("prog_exit", 2'd0, 1'b0, 1'b0);
        do_reset();
        read_burst("rom_rd02", 6'h02, 1);
        read_burst("rom_rd0_3", 6'h00, 4);
    endtask

    task automatic test_write_once();
        write_pulse(6'h25, 8'hA5, 3, 8'h5A);
        check_state("wr_once_idle", 2'd0, 1'b0, 1'b0);
        read_burst("wr_once_rd", 6'h25, 1);
    endtask

    task automatic test_burst();
        for (int i = 0; i < 3; i++) write_pulse(6'h20 + 6'(i), 8'($urandom_range(0, 255)), 1, 8'h00);
        read_burst("burst", 6'h20, 3);
    endtask

    task automatic test_rom_write();
        write_pulse(6'h03, 8'hFF, 1, 8'hFF);
        check_state("rom_wr_err", 2'd0, 1'b1, 1'b0);
        read_burst("rom_wr_rd", 6'h03, 1);
        step(); step();
        check_state("rom_wr_sticky", 2'd0, 1'b1, 1'b0);
        do_reset();
        check_state("rom_wr_clear", 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_conflict();
        write_pulse(6'h26, 8'h3C, 1, 8'h00);
        bus.rd = 1'b1; bus.wr = 1'b1; bus.addr = 6'h26;
        tb_oe = 1'b1; tb_dout = 8'h77;
        step();
        err_m = 1'b1;
        check_state("rdwr_conflict", 2'd0, 1'b1, 1'b0);
        bus.rd = 1'b0; bus.wr = 1'b0; tb_oe = 1'b0;
        step();
        read_burst("rdwr_noram", 6'h26, 1);
        do_reset();
        // wr while a read is active: flagged, not written
        bus.rd = 1'b1; bus.addr = 6'h27;
        step();
        bus.wr = 1'b1;
        step();
        err_m = 1'b1;
        check_state("wr_in_rd", 2'd1, 1'b1, 1'b1);
        bus.rd = 1'b0; bus.wr = 1'b0;
        step();
        read_burst("wr_in_rd_noram", 6'h27, 1);
        // rd while a write is held
        do_reset();
        bus.wr = 1'b1; bus.addr = 6'h28; tb_oe = 1'b1; tb_dout = 8'h96;
        step();
        ram_m[8] = 8'h96;
        tb_oe = 1'b0;
        bus.rd = 1'b1;
        step();
        err_m = 1'b1;
        check_state("rd_in_wr", 2'd2, 1'b1, 1'b0);
        bus.rd = 1'b0; bus.wr = 1'b0;
        step();
        read_burst("rd_in_wr_ram", 6'h28, 1);
        do_reset();
    endtask

    task automatic test_reset_mid();
        write_pulse(6'h25, 8'hC3, 1, 8'h00);
        bus.rd = 1'b1; bus.addr = 6'h25;
        step();
        check_state("mid_rd_active", 2'd1, 1'b0, 1'b1);
        reset = 1'b0;
        step();
        check_state("mid_rd_reset", 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) ram_m[i] = 8'h00;
        bus.rd = 1'b0;
        // write issued on a reset edge must not land
        bus.wr = 1'b1; bus.addr = 6'h21; tb_oe = 1'b1; tb_dout = 8'hEE;
        step();
        bus.wr = 1'b0; tb_oe = 1'b0;
        reset = 1'b1;
        step();
        read_burst("ram_cleared", 6'h20, 32);
        read_burst("rom_kept", 6'h00, 4);
    endtask

    task automatic test_random();
        logic [5:0] a;
        for (int n = 0; n < 20; n++) begin
            a = 6'($urandom_range(32, 63));
            if ($urandom_range(0, 1) == 1) write_pulse(a, 8'($urandom_range(0, 255)), $urandom_range(1, 3), 8'($urandom_range(0, 255)));
            else read_burst("rand_rd", a, 1);
        end
        read_burst("rand_final", 6'h20, 32);
    endtask

    initial begin
        err_m = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rom_m[i] = 8'hxx;
            ram_m[i] = 8'h00;
        end
        test_reset();
        test_prog();
        test_write_once();
        test_burst();
        test_rom_write();
        test_conflict();
        test_reset_mid();
        test_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
